// File: rtl/inst_seq_pkg.sv
// Shared types and constants for the instruction-sequence driver.
// Provides mode/state enums, the RV32 NOP word and the index-width helper.
package inst_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_ONESHOT = 2'd0,
    SEQ_LOOP    = 2'd1,
    SEQ_HOLD    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  localparam int unsigned SEQ_DEPTH_DEF = 16;
  localparam int unsigned SEQ_IDXW_DEF  = $clog2(SEQ_DEPTH_DEF);

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_seq_table.sv
// Sequence table: DEPTH x IW flop array, one write port, async read.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i -> rdata_o read port.
module inst_seq_table
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IW    = 32
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [idx_w(DEPTH)-1:0]   waddr_i,
  input  logic [IW-1:0]             wdata_i,
  input  logic [idx_w(DEPTH)-1:0]   raddr_i,
  output logic [IW-1:0]             rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];

  // Contents survive reset on purpose so a restart replays the same program.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_seq_driver.sv
// Instruction-stream driver: replays a programmed table one-shot, looped or held.
// Ports: cfg_* table/sequence setup, start/abort control, fetch_ready handshake,
// inst_o/inst_valid_o to core, idx_o/issue_cnt_o/busy_o/done_o status.
// Option: INST_SEQ_NOP_PAD_EN marks NOP padding valid while DONE.
module inst_seq_driver
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = SEQ_DEPTH_DEF,
  parameter int IW    = 32,
  parameter int CNTW  = 16
) (
  input  logic                      clk,
  input  logic                      reset_x,
  input  logic                      cfg_we,
  input  logic [idx_w(DEPTH)-1:0]   cfg_addr,
  input  logic [IW-1:0]             cfg_data,
  input  logic [idx_w(DEPTH):0]     cfg_len,
  input  logic [1:0]                cfg_mode,
  input  logic [CNTW-1:0]           cfg_loops,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      fetch_ready,
  output logic [IW-1:0]             inst_o,
  output logic                      inst_valid_o,
  output logic [idx_w(DEPTH)-1:0]   idx_o,
  output logic [CNTW-1:0]           issue_cnt_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int IXW = idx_w(DEPTH);
  localparam int LW  = IXW + 1;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [LW-1:0]   len_q, len_d;
  logic [CNTW-1:0] loops_q, loops_d;
  logic [CNTW-1:0] pass_q, pass_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IXW-1:0]  idx_q, idx_d;
  logic [IW-1:0]   rd_data;
  logic            busy, fire, last, final_pass;

  assign busy = (state_q == ST_RUN);
  assign fire = busy & fetch_ready;
  assign last = ({1'b0, idx_q} == len_q - LW'(1));
  assign final_pass = (loops_q != '0) &&
                      (pass_q == loops_q - CNTW'(1));

  inst_seq_table #(
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_table (
    .clk    (clk),
    .we_i   (cfg_we & ~busy),
    .waddr_i(cfg_addr),
    .wdata_i(cfg_data),
    .raddr_i(idx_q),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      loops_q <= '0;
      pass_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      loops_q <= loops_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    loops_d = loops_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (start && !busy) begin
      mode_d  = cfg_mode;
      len_d   = cfg_len;
      loops_d = cfg_loops;
      pass_d  = '0;
      cnt_d   = '0;
      idx_d   = '0;
      state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
    end else if (fire) begin
      if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
      if (mode_q == SEQ_HOLD) begin
        idx_d = '0;
      end else if (!last) begin
        idx_d = idx_q + IXW'(1);
      end else if (mode_q == SEQ_LOOP && !final_pass) begin
        // loops==0 never reaches final_pass, so it wraps forever
        idx_d  = '0;
        pass_d = pass_q + CNTW'(1);
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  assign busy_o      = busy;
  assign done_o      = (state_q == ST_DONE);
  assign idx_o       = idx_q;
  assign issue_cnt_o = cnt_q;
  assign inst_o      = busy ? rd_data : IW'(RV32_NOP);

`ifdef INST_SEQ_NOP_PAD_EN
  assign inst_valid_o = busy | done_o;
`else
  assign inst_valid_o = busy;
`endif

endmodule

// File: tb/tb_inst_seq_driver.sv
// Directed + randomized bench for inst_seq_driver.
// Reference model derives issue order from mode/len/loops arithmetic.
module tb_inst_seq_driver;

  localparam int DEPTH = 16;
  localparam int IW    = 32;
  localparam int CNTW  = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef INST_SEQ_NOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_x = 1'b0;
  logic            cfg_we = 1'b0;
  logic [3:0]      cfg_addr = '0;
  logic [IW-1:0]   cfg_data = '0;
  logic [4:0]      cfg_len = '0;
  logic [1:0]      cfg_mode = '0;
  logic [CNTW-1:0] cfg_loops = '0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            fetch_ready = 1'b0;
  logic [IW-1:0]   inst_o;
  logic            inst_valid_o;
  logic [3:0]      idx_o;
  logic [CNTW-1:0] issue_cnt_o;
  logic            busy_o;
  logic            done_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] tbl [DEPTH];

  always #5 clk = ~clk;

  inst_seq_driver #(
    .DEPTH(DEPTH),
    .IW   (IW),
    .CNTW (CNTW)
  ) dut (
    .clk         (clk),
    .reset_x     (reset_x),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_len     (cfg_len),
    .cfg_mode    (cfg_mode),
    .cfg_loops   (cfg_loops),
    .start       (start),
    .abort       (abort),
    .fetch_ready (fetch_ready),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o),
    .idx_o       (idx_o),
    .issue_cnt_o (issue_cnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = d;
    tbl[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  function automatic int exp_idx(input int mode, input int len, input int k);
    if (mode == 2) return 0;
    return k % len;
  endfunction

  // Caller is at a negedge; ends at a negedge with fetch_ready low.
  task automatic run_seq(input int mode, input int len, input int loops,
                         input int n_tgt, input bit fin,
                         input logic [31:0] pat, input bit use_pat);
    int total, k, cyc, ei;
    bit fr;
    if ((mode == 1 && loops == 0) || mode == 2) total = n_tgt;
    else if (mode == 1) total = len * loops;
    else total = len;
    cfg_len = 5'(len);
    cfg_mode = 2'(mode);
    cfg_loops = CNTW'(loops);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b0;
    k = 0;
    cyc = 0;
    while (k < total && cyc < 2000) begin
      ei = exp_idx(mode, len, k);
      chk("run_busy", 32'(busy_o), 32'd1);
      chk("run_valid", 32'(inst_valid_o), 32'd1);
      chk("run_idx", 32'(idx_o), 32'(ei));
      chk("run_inst", inst_o, tbl[ei]);
      chk("run_cnt", 32'(issue_cnt_o), 32'((k > 255) ? 255 : k));
      if (use_pat) fr = (cyc < 32) ? pat[cyc] : 1'b1;
      else fr = ($urandom_range(0, 3) != 0);
      fetch_ready = fr;
      @(negedge clk);
      if (fr) k++;
      cyc++;
    end
    fetch_ready = 1'b0;
    chk("budget", 32'(k), 32'(total));
    if (fin) begin
      chk("end_done", 32'(done_o), 32'd1);
      chk("end_busy", 32'(busy_o), 32'd0);
      chk("end_valid", 32'(inst_valid_o), 32'(PAD));
      chk("end_inst", inst_o, NOP);
      chk("end_cnt", 32'(issue_cnt_o), 32'(total));
    end else begin
      chk("hold_busy", 32'(busy_o), 32'd1);
      chk("hold_done", 32'(done_o), 32'd0);
      chk("hold_cnt", 32'(issue_cnt_o),
          32'((total > 255) ? 255 : total));
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_valid", 32'(inst_valid_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
  endtask

  initial begin
    int md, ln, lp;
    logic [31:0] nw;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    reset_x = 1'b1;
    @(negedge clk);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_cnt", 32'(issue_cnt_o), 32'd0);
    chk("rst_inst", inst_o, NOP);

    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);

    // one-shot single jal
    wr(0, 32'h0040_006F);
    run_seq(0, 1, 0, 0, 1'b1, 32'h1, 1'b1);

    // backpressure freeze at entry 1
    run_seq(0, 3, 0, 0, 1'b1, 32'h61, 1'b1);

    // loop len 2 x3
    run_seq(1, 2, 3, 0, 1'b1, 32'h0, 1'b0);

    // hold, then a write while busy must be dropped
    wr(0, 32'h0010_0093);
    run_seq(2, 4, 0, 10, 1'b0, 32'h0, 1'b0);
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 32'hDEAD_BEEF;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    chk("busy_wr_drop", inst_o, tbl[0]);
    do_abort();

    // counter saturation
    run_seq(2, 1, 0, 300, 1'b0, 32'h0, 1'b0);
    do_abort();

    // abort beats start mid-run, then zero-length start
    run_seq(1, 2, 0, 5, 1'b0, 32'h0, 1'b0);
    start = 1'b1;
    do_abort();
    start = 1'b0;
    run_seq(0, 0, 0, 0, 1'b1, 32'h0, 1'b0);

    // write and start together: start sees the new word
    nw = $urandom;
    cfg_we = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = nw;
    tbl[0] = nw;
    run_seq(0, 3, 0, 0, 1'b1, 32'h0, 1'b0);

    // full depth, reserved mode, random mixes
    run_seq(1, 16, 2, 0, 1'b1, 32'h0, 1'b0);
    run_seq(3, 5, 0, 0, 1'b1, 32'h0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      md = $urandom_range(0, 1);
      ln = $urandom_range(1, 16);
      lp = $urandom_range(1, 3);
      wr($urandom_range(0, 15), $urandom);
      run_seq(md, ln, lp, 0, 1'b1, 32'h0, 1'b0);
    end

    // async reset mid-loop, table retained
    run_seq(1, 3, 0, 4, 1'b0, 32'h0, 1'b0);
    #2 reset_x = 1'b0;
    #1;
    chk("areset_busy", 32'(busy_o), 32'd0);
    chk("areset_idx", 32'(idx_o), 32'd0);
    chk("areset_cnt", 32'(issue_cnt_o), 32'd0);
    chk("areset_valid", 32'(inst_valid_o), 32'd0);
    chk("areset_inst", inst_o, NOP);
    chk("areset_done", 32'(done_o), 32'd0);
    @(negedge clk);
    reset_x = 1'b1;
    @(negedge clk);
    run_seq(1, 3, 2, 0, 1'b1, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
